// File: rtl/opt_step_sequencer_pkg.sv
// Shared types and constants for the opt step sequencer.
// Holds the move/command encodings, the step-ROM entry type, the FSM state
// enum and the move legality helper used by the sequencer.
package opt_step_sequencer_pkg;

   localparam int K_W           = 7;
   localparam int CITY_NUM_DFLT = 16;
   localparam int STEPS_TWO     = 5;
   localparam int STEPS_OR      = 7;
   localparam int STEP_W        = 3;

   typedef enum logic [1:0] {
      CMD_TWO = 2'd0,
      CMD_OR0 = 2'd1,
      CMD_OR1 = 2'd2,
      CMD_THR = 2'd3
   } opt_command_t;

   typedef struct packed {
      opt_command_t   command;
      logic [K_W-1:0] k;
      logic [K_W-1:0] l;
   } opt_t;

   // N = the city itself, M = predecessor, P = successor
   typedef enum logic [2:0] {
      SEL_KN = 3'd0,
      SEL_KM = 3'd1,
      SEL_KP = 3'd2,
      SEL_LN = 3'd3,
      SEL_LM = 3'd4,
      SEL_LP = 3'd5
   } distance_select_t;

   typedef enum logic [1:0] {
      OP_ZERO = 2'd0,
      OP_PLS  = 2'd1,
      OP_MNS  = 2'd2
   } distance_op_t;

   typedef struct packed {
      distance_select_t select;
      distance_op_t     op;
   } distance_command_t;

   typedef logic signed [20:0] delta_data_t;

   typedef struct packed {
      distance_select_t from;
      distance_select_t to;
      distance_op_t     op;
   } dist_step_t;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_CHECK = 3'd1,
      ST_ISSUE = 3'd2,
      ST_WAIT  = 3'd3,
      ST_JUDGE = 3'd4,
      ST_EXCH  = 3'd5
   } opt_seq_state_t;

   function automatic dist_step_t mk_step(input distance_select_t from,
                                          input distance_select_t to,
                                          input distance_op_t op);
      dist_step_t s;
      s.from = from;
      s.to   = to;
      s.op   = op;
      return s;
   endfunction

   // A move is legal only when both positions are real cities and the
   // ordering constraint of its move type holds; THR is never legal.
   function automatic logic opt_is_legal(input opt_t opt, input int city_num);
      logic in_range;
      logic order_ok;
      in_range = (int'(opt.k) < city_num) && (int'(opt.l) < city_num);
      case (opt.command)
         CMD_TWO, CMD_OR0: order_ok = (opt.k < opt.l);
         CMD_OR1:          order_ok = (int'(opt.k) > (int'(opt.l) + 1));
         default:          order_ok = 1'b0;
      endcase
      return in_range && order_ok;
   endfunction

endpackage

// File: rtl/opt_step_sequencer_if.sv
// Handshake bundle between the sequencer and its neighbours (move generator,
// distance datapath, Metropolis judge, exchange controller).
// master: the sequencer view.  slave: the environment view.
interface opt_step_sequencer_if;
   import opt_step_sequencer_pkg::*;

   logic              opt_valid;
   logic              opt_ready;
   opt_t              opt_in;
   logic              dist_valid;
   logic              dist_ready;
   distance_command_t dist_cmd;
   distance_select_t  dist_to;
   logic              delta_valid;
   delta_data_t       delta_in;
   logic              judge_valid;
   logic              judge_ready;
   delta_data_t       judge_delta;
   opt_t              judge_opt;
   logic              judge_illegal;
   logic              exch_req;
   logic              exch_done;

   modport master (
      input  opt_valid, opt_in, dist_ready, delta_valid, delta_in,
             judge_ready, exch_done,
      output opt_ready, dist_valid, dist_cmd, dist_to, judge_valid,
             judge_delta, judge_opt, judge_illegal, exch_req
   );

   modport slave (
      output opt_valid, opt_in, dist_ready, delta_valid, delta_in,
             judge_ready, exch_done,
      input  opt_ready, dist_valid, dist_cmd, dist_to, judge_valid,
             judge_delta, judge_opt, judge_illegal, exch_req
   );
endinterface

// File: rtl/opt_step_sequencer_rom.sv
// opt_step_rom: combinational step table.
// Maps {move command, step index} to one distance step plus a last flag.
// Ports: command (in), idx (in), step (out), last (out).
module opt_step_rom
   import opt_step_sequencer_pkg::*;
(
   input  opt_command_t     command,
   input  logic [STEP_W-1:0] idx,
   output dist_step_t       step,
   output logic             last
);

   // Step lookup; unsupported commands yield a single accumulator clear.
   always_comb begin
      step = mk_step(SEL_KN, SEL_KN, OP_ZERO);
      last = 1'b1;
      case (command)
         CMD_TWO: begin
            last = (idx == STEP_W'(STEPS_TWO - 1));
            case (idx)
               3'd0:    step = mk_step(SEL_KN, SEL_KN, OP_ZERO);
               3'd1:    step = mk_step(SEL_KM, SEL_LN, OP_PLS);
               3'd2:    step = mk_step(SEL_KN, SEL_LP, OP_PLS);
               3'd3:    step = mk_step(SEL_KM, SEL_KN, OP_MNS);
               3'd4:    step = mk_step(SEL_LN, SEL_LP, OP_MNS);
               default: step = mk_step(SEL_KN, SEL_KN, OP_ZERO);
            endcase
         end
         CMD_OR0, CMD_OR1: begin
            last = (idx == STEP_W'(STEPS_OR - 1));
            case (idx)
               3'd0:    step = mk_step(SEL_KN, SEL_KN, OP_ZERO);
               3'd1:    step = mk_step(SEL_KM, SEL_KP, OP_PLS);
               3'd2:    step = mk_step(SEL_LN, SEL_KN, OP_PLS);
               3'd3:    step = mk_step(SEL_KN, SEL_LP, OP_PLS);
               3'd4:    step = mk_step(SEL_KM, SEL_KN, OP_MNS);
               3'd5:    step = mk_step(SEL_KN, SEL_KP, OP_MNS);
               3'd6:    step = mk_step(SEL_LN, SEL_LP, OP_MNS);
               default: step = mk_step(SEL_KN, SEL_KN, OP_ZERO);
            endcase
         end
         default: begin
            step = mk_step(SEL_KN, SEL_KN, OP_ZERO);
            last = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/opt_step_sequencer.sv
// opt_step_sequencer: per-replica move controller.
// Accepts one move, checks legality, streams its distance-accumulate steps,
// collects the returned delta, hands it to the judge, and every
// OPT_PER_EXCH completed moves stalls for a replica-exchange phase.
// Ports: clk, reset (async, active-high), bus (opt_step_sequencer_if.master).
// Optional macro OPT_STEP_STATS_EN adds stat_moves, stat_illegal, stat_stall.
module opt_step_sequencer
   import opt_step_sequencer_pkg::*;
#(
   parameter int OPT_PER_EXCH = 1024,
   parameter int CNT_W        = $clog2(OPT_PER_EXCH + 1),
   parameter int CITY_NUM     = CITY_NUM_DFLT
) (
   input  logic                 clk,
   input  logic                 reset,
   opt_step_sequencer_if.master bus
`ifdef OPT_STEP_STATS_EN
   ,
   output logic [31:0]          stat_moves,
   output logic [31:0]          stat_illegal,
   output logic [31:0]          stat_stall
`endif
);

   opt_seq_state_t    state_r;
   opt_t              opt_r;
   logic [STEP_W-1:0] step_idx_r;
   logic              last_r;
   logic [CNT_W-1:0]  cnt_r;
   logic              opt_ready_r;
   logic              dist_valid_r;
   distance_command_t dist_cmd_r;
   distance_select_t  dist_to_r;
   logic              judge_valid_r;
   delta_data_t       judge_delta_r;
   logic              judge_illegal_r;
   logic              exch_req_r;

   logic [STEP_W-1:0] rom_idx_s;
   dist_step_t        rom_step_s;
   logic              rom_last_s;
   logic              legal_s;
   logic              dist_fire_s;
   logic              judge_fire_s;
   logic [CNT_W-1:0]  cnt_next_s;

   // ROM is addressed one step ahead so the next step can be registered on
   // the completing handshake; CHECK preloads step 0.
   always_comb begin
      if (state_r == ST_ISSUE) begin
         rom_idx_s = step_idx_r + STEP_W'(1);
      end else begin
         rom_idx_s = '0;
      end
   end

   opt_step_rom u_rom (
      .command (opt_r.command),
      .idx     (rom_idx_s),
      .step    (rom_step_s),
      .last    (rom_last_s)
   );

   assign legal_s      = opt_is_legal(opt_r, CITY_NUM);
   assign dist_fire_s  = dist_valid_r && bus.dist_ready;
   assign judge_fire_s = judge_valid_r && bus.judge_ready;
   assign cnt_next_s   = cnt_r + CNT_W'(1);

   // Main sequencer FSM with registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r         <= ST_IDLE;
         opt_r           <= '0;
         step_idx_r      <= '0;
         last_r          <= 1'b0;
         cnt_r           <= '0;
         opt_ready_r     <= 1'b0;
         dist_valid_r    <= 1'b0;
         dist_cmd_r      <= '0;
         dist_to_r       <= SEL_KN;
         judge_valid_r   <= 1'b0;
         judge_delta_r   <= '0;
         judge_illegal_r <= 1'b0;
         exch_req_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.opt_valid && opt_ready_r) begin
                  opt_r       <= bus.opt_in;
                  opt_ready_r <= 1'b0;
                  state_r     <= ST_CHECK;
               end else begin
                  opt_ready_r <= 1'b1;
               end
            end
            ST_CHECK: begin
               step_idx_r <= '0;
               if (legal_s) begin
                  dist_valid_r      <= 1'b1;
                  dist_cmd_r.select <= rom_step_s.from;
                  dist_cmd_r.op     <= rom_step_s.op;
                  dist_to_r         <= rom_step_s.to;
                  last_r            <= rom_last_s;
                  state_r           <= ST_ISSUE;
               end else begin
                  judge_valid_r   <= 1'b1;
                  judge_delta_r   <= '0;
                  judge_illegal_r <= 1'b1;
                  state_r         <= ST_JUDGE;
               end
            end
            ST_ISSUE: begin
               // Outputs only change on a completed step, so they stay
               // stable while the datapath stalls.
               if (dist_fire_s) begin
                  if (last_r) begin
                     dist_valid_r <= 1'b0;
                     state_r      <= ST_WAIT;
                  end else begin
                     step_idx_r        <= step_idx_r + STEP_W'(1);
                     dist_cmd_r.select <= rom_step_s.from;
                     dist_cmd_r.op     <= rom_step_s.op;
                     dist_to_r         <= rom_step_s.to;
                     last_r            <= rom_last_s;
                  end
               end else begin
                  state_r <= ST_ISSUE;
               end
            end
            ST_WAIT: begin
               if (bus.delta_valid) begin
                  judge_delta_r   <= bus.delta_in;
                  judge_illegal_r <= 1'b0;
                  judge_valid_r   <= 1'b1;
                  state_r         <= ST_JUDGE;
               end else begin
                  state_r <= ST_WAIT;
               end
            end
            ST_JUDGE: begin
               if (judge_fire_s) begin
                  judge_valid_r   <= 1'b0;
                  judge_illegal_r <= 1'b0;
                  cnt_r           <= cnt_next_s;
                  if (cnt_next_s == CNT_W'(OPT_PER_EXCH)) begin
                     exch_req_r <= 1'b1;
                     state_r    <= ST_EXCH;
                  end else begin
                     opt_ready_r <= 1'b1;
                     state_r     <= ST_IDLE;
                  end
               end else begin
                  state_r <= ST_JUDGE;
               end
            end
            ST_EXCH: begin
               if (bus.exch_done) begin
                  exch_req_r  <= 1'b0;
                  cnt_r       <= '0;
                  opt_ready_r <= 1'b1;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r <= ST_EXCH;
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               dist_valid_r  <= 1'b0;
               judge_valid_r <= 1'b0;
               exch_req_r    <= 1'b0;
               opt_ready_r   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.opt_ready     = opt_ready_r;
   assign bus.dist_valid    = dist_valid_r;
   assign bus.dist_cmd      = dist_cmd_r;
   assign bus.dist_to       = dist_to_r;
   assign bus.judge_valid   = judge_valid_r;
   assign bus.judge_delta   = judge_delta_r;
   assign bus.judge_opt     = opt_r;
   assign bus.judge_illegal = judge_illegal_r;
   assign bus.exch_req      = exch_req_r;

`ifdef OPT_STEP_STATS_EN
   logic [31:0] stat_moves_r;
   logic [31:0] stat_illegal_r;
   logic [31:0] stat_stall_r;

   // Saturating activity counters, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stat_moves_r   <= 32'd0;
         stat_illegal_r <= 32'd0;
         stat_stall_r   <= 32'd0;
      end else begin
         if (judge_fire_s && (stat_moves_r != 32'hFFFF_FFFF)) begin
            stat_moves_r <= stat_moves_r + 32'd1;
         end
         if (judge_fire_s && judge_illegal_r && (stat_illegal_r != 32'hFFFF_FFFF)) begin
            stat_illegal_r <= stat_illegal_r + 32'd1;
         end
         if ((state_r == ST_ISSUE) && dist_valid_r && !bus.dist_ready &&
             (stat_stall_r != 32'hFFFF_FFFF)) begin
            stat_stall_r <= stat_stall_r + 32'd1;
         end
      end
   end

   assign stat_moves   = stat_moves_r;
   assign stat_illegal = stat_illegal_r;
   assign stat_stall   = stat_stall_r;
`endif

endmodule

// File: tb/tb_opt_step_sequencer.sv
// Self-checking bench for opt_step_sequencer (OPT_PER_EXCH = 4, 16 cities).
module tb_opt_step_sequencer;
   import opt_step_sequencer_pkg::*;

   logic clk;
   logic rst;
   int   total_cnt = 0;
   int   pass_cnt  = 0;

   logic [7:0]  exp_dist_q[$];
   logic [37:0] exp_judge_q[$];

   opt_step_sequencer_if intf ();

`ifdef OPT_STEP_STATS_EN
   logic [31:0] stat_moves, stat_illegal, stat_stall;
`endif

   opt_step_sequencer #(.OPT_PER_EXCH(4)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (intf)
`ifdef OPT_STEP_STATS_EN
      ,
      .stat_moves   (stat_moves),
      .stat_illegal (stat_illegal),
      .stat_stall   (stat_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] exp_step(input opt_command_t c, input int i);
      logic [7:0] s;
      s = {SEL_KN, SEL_KN, OP_ZERO};
      if (c == CMD_TWO) begin
         case (i)
            1: s = {SEL_KM, SEL_LN, OP_PLS};
            2: s = {SEL_KN, SEL_LP, OP_PLS};
            3: s = {SEL_KM, SEL_KN, OP_MNS};
            4: s = {SEL_LN, SEL_LP, OP_MNS};
            default: s = {SEL_KN, SEL_KN, OP_ZERO};
         endcase
      end else begin
         case (i)
            1: s = {SEL_KM, SEL_KP, OP_PLS};
            2: s = {SEL_LN, SEL_KN, OP_PLS};
            3: s = {SEL_KN, SEL_LP, OP_PLS};
            4: s = {SEL_KM, SEL_KN, OP_MNS};
            5: s = {SEL_KN, SEL_KP, OP_MNS};
            6: s = {SEL_LN, SEL_LP, OP_MNS};
            default: s = {SEL_KN, SEL_KN, OP_ZERO};
         endcase
      end
      return s;
   endfunction

   function automatic bit bench_legal(input opt_command_t c, input int k, input int l);
      if (k >= 16 || l >= 16) return 1'b0;
      if (c == CMD_TWO || c == CMD_OR0) return k < l;
      if (c == CMD_OR1) return k > l + 1;
      return 1'b0;
   endfunction

   // Distance step scoreboard: every handshake pops one expected step; while
   // stalled the presented step must already be the expected next one.
   always @(negedge clk) begin
      logic [7:0] cur;
      cur = {intf.dist_cmd.select, intf.dist_to, intf.dist_cmd.op};
      if (!rst && intf.dist_valid) begin
         if (exp_dist_q.size() == 0) chk("dist_unexpected", 64'd1, 64'd0);
         else if (intf.dist_ready) chk("dist_step", {56'd0, cur}, {56'd0, exp_dist_q.pop_front()});
         else chk("dist_stall_hold", {56'd0, cur}, {56'd0, exp_dist_q[0]});
      end
   end

   // Judge scoreboard: {illegal, opt, delta} checked on each judge handshake.
   always @(negedge clk) begin
      if (!rst && intf.judge_valid && intf.judge_ready) begin
         if (exp_judge_q.size() == 0) chk("judge_unexpected", 64'd1, 64'd0);
         else chk("judge_out", {26'd0, intf.judge_illegal, intf.judge_opt, intf.judge_delta},
                  {26'd0, exp_judge_q.pop_front()});
      end
   end

   task automatic run_move(input opt_command_t c, input int k, input int l,
                           input logic [20:0] d, input bit toggle, input int hold);
      opt_t o;
      bit   legal;
      int   n;
      int   ticks;
      bit   ok;
      o.command = c;
      o.k       = 7'(k);
      o.l       = 7'(l);
      legal     = bench_legal(c, k, l);
      n         = (c == CMD_TWO) ? 5 : 7;
      if (legal) for (int i = 0; i < n; i++) exp_dist_q.push_back(exp_step(c, i));
      exp_judge_q.push_back({!legal, o, (legal ? d : 21'd0)});
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (intf.opt_ready) begin ok = 1'b1; break; end
         tick();
      end
      chk("opt_ready_wait", {63'd0, ok}, 64'd1);
      if (hold > 0) intf.judge_ready = 1'b0;
      intf.opt_valid = 1'b1;
      intf.opt_in    = o;
      tick();
      intf.opt_valid = 1'b0;
      chk("check_no_dist", {63'd0, intf.dist_valid}, 64'd0);
      tick();
      chk("first_dist", {63'd0, intf.dist_valid}, {63'd0, legal});
      chk("illegal_judge", {62'd0, intf.judge_valid, intf.judge_illegal}, {62'd0, !legal, !legal});
      if (legal) begin
         ticks = 0;
         for (int i = 0; i < 60; i++) begin
            if (exp_dist_q.size() == 0) break;
            if (toggle) intf.dist_ready = ~intf.dist_ready;
            tick();
            ticks++;
         end
         intf.dist_ready = 1'b1;
         chk("dist_steps_done", 64'(exp_dist_q.size()), 64'd0);
         if (!toggle) chk("issue_cycles", 64'(ticks), 64'(n));
         chk("wait_no_dist", {63'd0, intf.dist_valid}, 64'd0);
         tick();
         tick();
         intf.delta_valid = 1'b1;
         intf.delta_in    = d;
         tick();
         intf.delta_valid = 1'b0;
         intf.delta_in    = 21'h15555;
      end
      for (int i = 0; i < hold; i++) begin
         chk("judge_hold_valid", {63'd0, intf.judge_valid}, 64'd1);
         chk("judge_hold_delta", {43'd0, intf.judge_delta}, {43'd0, d});
         chk("judge_hold_opt", {48'd0, intf.judge_opt}, {48'd0, o});
         intf.delta_valid = (i == 3);
         intf.delta_in    = 21'h1FFFFF;
         tick();
      end
      intf.delta_valid = 1'b0;
      intf.judge_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         if (exp_judge_q.size() == 0) break;
         tick();
      end
      chk("judge_done", 64'(exp_judge_q.size()), 64'd0);
   endtask

   task automatic pulse_exch;
      intf.exch_done = 1'b1;
      tick();
      intf.exch_done = 1'b0;
   endtask

   initial begin
      intf.opt_valid   = 1'b0;
      intf.opt_in      = '0;
      intf.dist_ready  = 1'b1;
      intf.delta_valid = 1'b0;
      intf.delta_in    = 21'd0;
      intf.judge_ready = 1'b1;
      intf.exch_done   = 1'b0;
      rst              = 1'b1;
      repeat (3) tick();
      chk("rst_opt_ready", {63'd0, intf.opt_ready}, 64'd0);
      chk("rst_outputs", {59'd0, intf.dist_valid, intf.judge_valid, intf.judge_illegal,
                          intf.exch_req, |intf.judge_delta}, 64'd0);
      chk("rst_dist_cmd", {56'd0, intf.dist_cmd, intf.dist_to}, 64'd0);
      rst = 1'b0;
      tick();
      tick();
      chk("idle_ready", {63'd0, intf.opt_ready}, 64'd1);

      // Four legal moves, the last of which triggers the exchange phase.
      run_move(CMD_TWO, 3, 10, 21'h08000, 1'b0, 0);
      run_move(CMD_OR1, 12, 4, 21'h1F0000, 1'b1, 0);
      run_move(CMD_OR0, 2, 9, 21'h00123, 1'b0, 0);
      chk("no_exch_at_3", {63'd0, intf.exch_req}, 64'd0);
      run_move(CMD_TWO, 1, 7, 21'h00400, 1'b0, 0);
      repeat (5) tick();
      chk("exch_req_hold", {62'd0, intf.exch_req, intf.opt_ready}, 64'd2);
      pulse_exch();
      chk("exch_released", {62'd0, intf.exch_req, intf.opt_ready}, 64'd1);

      // Illegal moves; the counter restarted, so the 4th one requests exchange.
      run_move(CMD_THR, 3, 10, 21'h00777, 1'b0, 0);
      run_move(CMD_TWO, 5, 5, 21'h00777, 1'b0, 0);
      run_move(CMD_OR1, 5, 4, 21'h00777, 1'b0, 0);
      chk("no_exch_after_restart", {63'd0, intf.exch_req}, 64'd0);
      run_move(CMD_TWO, 31, 3, 21'h00777, 1'b0, 0);
      tick();
      chk("exch_req_illegal", {62'd0, intf.exch_req, intf.opt_ready}, 64'd2);
      pulse_exch();
      pulse_exch();
      tick();
      chk("spurious_exch_done", {62'd0, intf.exch_req, intf.opt_ready}, 64'd1);

      // Judge back-pressure with a spurious delta pulse while in JUDGE.
      run_move(CMD_TWO, 4, 9, 21'h0ABCD, 1'b0, 10);

      // Reset while step 3 is presented.
      for (int i = 0; i < 5; i++) exp_dist_q.push_back(exp_step(CMD_TWO, i));
      intf.opt_in.command = CMD_TWO;
      intf.opt_in.k       = 7'd3;
      intf.opt_in.l       = 7'd10;
      intf.opt_valid      = 1'b1;
      tick();
      intf.opt_valid = 1'b0;
      repeat (4) tick();
      chk("step3_presented", {56'd0, intf.dist_cmd.select, intf.dist_to, intf.dist_cmd.op},
          {56'd0, exp_step(CMD_TWO, 3)});
      chk("steps_left", 64'(exp_dist_q.size()), 64'd2);
      rst = 1'b1;
      tick();
      chk("mid_rst_outputs", {58'd0, intf.opt_ready, intf.dist_valid, intf.judge_valid,
                              intf.judge_illegal, intf.exch_req, |intf.judge_delta}, 64'd0);
      exp_dist_q.delete();
      exp_judge_q.delete();
      rst = 1'b0;
      run_move(CMD_TWO, 3, 10, 21'h00055, 1'b0, 0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
